// File: rtl/sram_sp_gen_if.sv
// Normal port, BIST port, power controls and read-back for sram_sp_gen.
// AW is derived from DEPTH exactly as inside the macro.
interface sram_sp_gen_if #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4096
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic             SLP;
   logic             SD;
   logic             BIST;
   logic             CEB;
   logic             WEB;
   logic [AW-1:0]    A;
   logic [WIDTH-1:0] D;
   logic [WIDTH-1:0] BWEB;
   logic             CEBM;
   logic             WEBM;
   logic [AW-1:0]    AM;
   logic [WIDTH-1:0] DM;
   logic [WIDTH-1:0] BWEBM;
   logic [WIDTH-1:0] Q;
   logic             QVLD;
   logic             READY;

   modport master (
      output SLP, SD, BIST,
      output CEB, WEB, A, D, BWEB,
      output CEBM, WEBM, AM, DM, BWEBM,
      input  Q, QVLD, READY
   );

   modport slave (
      input  SLP, SD, BIST,
      input  CEB, WEB, A, D, BWEB,
      input  CEBM, WEBM, AM, DM, BWEBM,
      output Q, QVLD, READY
   );
endinterface

// File: rtl/sram_sp_gen.sv
// Single-port SRAM model with BIST mux, bit-write mask and sleep/shutdown power FSM; read latency 1
// (2 with SRAM_SP_GEN_OUT_REG_EN); accesses are ignored whenever READY is low, there is no stalling.
module sram_sp_gen #(
   parameter int WIDTH       = 32,
   parameter int DEPTH       = 4096,
   parameter int WAKE_CYCLES = 4
) (
   input  logic          CLK,
   input  logic          RST,
   sram_sp_gen_if.slave  bus
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [7:0] WAKE_LOAD = 8'(WAKE_CYCLES - 1);

   typedef enum logic [1:0] {
      ST_ACTIVE   = 2'd0,
      ST_SLEEP    = 2'd1,
      ST_SHUTDOWN = 2'd2,
      ST_WAKE     = 2'd3
   } pwr_state_e;

   pwr_state_e       state_q;
   logic [7:0]       wake_cnt_q;
   logic             ready_q;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] q_q, q_d;
   logic             qvld_q, qvld_d;

   logic             ce_n;
   logic             we_n;
   logic [AW-1:0]    addr;
   logic [WIDTH-1:0] wdata;
   logic [WIDTH-1:0] wmask_n;
   logic             in_range;
   logic             acc;
   logic             sd_entry;

   always_comb begin
      ce_n    = bus.CEB;
      we_n    = bus.WEB;
      addr    = bus.A;
      wdata   = bus.D;
      wmask_n = bus.BWEB;
      if (bus.BIST) begin
         ce_n    = bus.CEBM;
         we_n    = bus.WEBM;
         addr    = bus.AM;
         wdata   = bus.DM;
         wmask_n = bus.BWEBM;
      end
   end

   assign in_range = (int'(addr) < DEPTH);
   // A power request on the same edge wins over any access presented with it.
   assign acc      = ready_q & ~ce_n & ~bus.SD & ~bus.SLP & ~RST;
   assign sd_entry = bus.SD & (state_q != ST_SHUTDOWN) & ~RST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= ST_ACTIVE;
         ready_q    <= 1'b1;
         wake_cnt_q <= 8'd0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            ST_ACTIVE: begin
               if (bus.SD) begin
                  state_q <= ST_SHUTDOWN;
               end else if (bus.SLP) begin
                  state_q <= ST_SLEEP;
               end else begin
                  ready_q <= 1'b1;
               end
            end
            ST_SLEEP: begin
               if (bus.SD) begin
                  state_q <= ST_SHUTDOWN;
               end else if (!bus.SLP) begin
                  state_q    <= ST_WAKE;
                  wake_cnt_q <= WAKE_LOAD;
               end
            end
            ST_SHUTDOWN: begin
               if (!bus.SD) begin
                  if (bus.SLP) begin
                     state_q <= ST_SLEEP;
                  end else begin
                     state_q    <= ST_WAKE;
                     wake_cnt_q <= WAKE_LOAD;
                  end
               end
            end
            ST_WAKE: begin
               if (bus.SD) begin
                  state_q <= ST_SHUTDOWN;
               end else if (bus.SLP) begin
                  state_q <= ST_SLEEP;
               end else if (wake_cnt_q == 8'd0) begin
                  state_q <= ST_ACTIVE;
                  ready_q <= 1'b1;
               end else begin
                  wake_cnt_q <= wake_cnt_q - 8'd1;
               end
            end
            default: begin
               state_q <= ST_ACTIVE;
               ready_q <= 1'b1;
            end
         endcase
      end
   end

   always_comb begin
      q_d    = q_q;
      qvld_d = 1'b0;
      if (sd_entry) begin
         q_d = '0;
      end else if (acc && we_n) begin
         qvld_d = 1'b1;
         q_d    = in_range ? mem_q[addr] : '0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_q    <= '0;
         qvld_q <= 1'b0;
      end else begin
         q_q    <= q_d;
         qvld_q <= qvld_d;
      end
   end

   // The array has no reset; shutdown deliberately poisons every word.
   always_ff @(posedge CLK) begin
      if (sd_entry) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= 'x;
         end
      end else if (acc && !we_n && in_range) begin
         mem_q[addr] <= (mem_q[addr] & wmask_n) | (wdata & ~wmask_n);
      end
   end

`ifdef SRAM_SP_GEN_OUT_REG_EN
   logic [WIDTH-1:0] q_out_q;
   logic             qvld_out_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         q_out_q    <= '0;
         qvld_out_q <= 1'b0;
      end else begin
         q_out_q    <= q_q;
         qvld_out_q <= qvld_q;
      end
   end

   assign bus.Q    = q_out_q;
   assign bus.QVLD = qvld_out_q;
`else
   assign bus.Q    = q_q;
   assign bus.QVLD = qvld_q;
`endif

   assign bus.READY = ready_q;

endmodule

// File: tb/tb_sram_sp_gen.sv
// Scoreboard bench for sram_sp_gen: expected read data is queued at issue and popped on QVLD.
// Works for either read latency since only QVLD is used to align results.
module tb_sram_sp_gen;
   localparam int WIDTH       = 32;
   localparam int DEPTH       = 3000;
   localparam int WAKE_CYCLES = 4;
   localparam int AW          = 12;

   logic CLK = 1'b0;
   logic RST;
   always #5 CLK = ~CLK;

   sram_sp_gen_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

   sram_sp_gen #(.WIDTH(WIDTH), .DEPTH(DEPTH), .WAKE_CYCLES(WAKE_CYCLES)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [31:0] model [DEPTH];
   logic [31:0] exp_q [$];
   logic [AW-1:0] addrs [8];

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (bus.QVLD === 1'b1) begin
         check_val("qvld_expected", 64'(exp_q.size() != 0), 64'd1);
         if (exp_q.size() != 0) check_val("rd_data", 64'(bus.Q), 64'(exp_q.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [31:0] m, input bit bist);
      if (bist) begin
         bus.BIST = 1'b1; bus.CEBM = 1'b0; bus.WEBM = 1'b0;
         bus.AM = a; bus.DM = d; bus.BWEBM = m;
         bus.CEB = 1'b0; bus.WEB = 1'b0; bus.A = 12'h020; bus.D = ~d; bus.BWEB = '0;
      end else begin
         bus.BIST = 1'b0; bus.CEB = 1'b0; bus.WEB = 1'b0;
         bus.A = a; bus.D = d; bus.BWEB = m;
      end
      if (int'(a) < DEPTH) model[a] = (model[a] & m) | (d & ~m);
      tick();
      bus.BIST = 1'b0; bus.CEB = 1'b1; bus.CEBM = 1'b1;
   endtask

   task automatic rd(input logic [AW-1:0] a);
      bus.BIST = 1'b0; bus.CEB = 1'b0; bus.WEB = 1'b1; bus.A = a;
      exp_q.push_back((int'(a) < DEPTH) ? model[a] : 32'h0);
      tick();
      bus.CEB = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 8 && exp_q.size() != 0; i++) tick();
      tick();
      check_val("drain", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic wait_ready(input string tag);
      int cnt = 0;
      while (bus.READY !== 1'b1 && cnt < 20) begin
         tick();
         cnt++;
      end
      check_val(tag, 64'(cnt), 64'(WAKE_CYCLES));
   endtask

   initial begin
      RST = 1'b1;
      bus.SLP = 0; bus.SD = 0; bus.BIST = 0;
      bus.CEB = 1; bus.WEB = 1; bus.A = '0; bus.D = '0; bus.BWEB = '1;
      bus.CEBM = 1; bus.WEBM = 1; bus.AM = '0; bus.DM = '0; bus.BWEBM = '1;
      tick();
      tick();
      check_val("rst_ready", 64'(bus.READY), 64'd1);
      check_val("rst_q", 64'(bus.Q), 64'd0);
      check_val("rst_qvld", 64'(bus.QVLD), 64'd0);
      RST = 1'b0;
      tick();

      // full write/read, then masked merge
      wr(12'h010, 32'hDEADBEEF, 32'h0, 1'b0);
      rd(12'h010);
      drain();
      wr(12'h010, 32'h12345678, 32'hFFFF0000, 1'b0);
      rd(12'h010);
      drain();
      check_val("masked_merge", 64'(model[12'h010]), 64'hDEAD5678);

      // BIST port selected: the normal port write to 0x020 must be ignored
      wr(12'h020, 32'h11111111, 32'h0, 1'b0);
      wr(12'h3FF, 32'hA5A5A5A5, 32'h0, 1'b1);
      rd(12'h3FF);
      rd(12'h020);
      drain();

      // out-of-range accesses against a set of known words
      addrs = '{12'h010, 12'h020, 12'h3FF, 12'd2999, 12'd953, 12'd0, 12'd1, 12'h7FF};
      for (int i = 0; i < 8; i++) wr(addrs[i], $urandom, 32'h0, 1'b0);
      rd(12'd3000);
      wr(12'd3001, 32'hFFFFFFFF, 32'h0, 1'b0);
      wr(12'd4095, 32'hFFFFFFFF, 32'h0, 1'b0);
      for (int i = 0; i < 8; i++) rd(addrs[i]);
      drain();

      // random mix of normal writes, BIST writes and back-to-back reads
      for (int i = 0; i < 60; i++) begin
         int op = $urandom_range(0, 3);
         logic [AW-1:0] a = addrs[$urandom_range(0, 7)];
         if (op == 0)      wr(a, $urandom, $urandom, 1'b0);
         else if (op == 1) wr(a, $urandom, $urandom, 1'b1);
         else              rd(a);
      end
      drain();

      // sleep: access on the entry edge and during sleep are ignored, Q retained
      wr(12'h010, 32'hCAFEF00D, 32'h0, 1'b0);
      rd(12'h010);
      drain();
      bus.SLP = 1'b1; bus.CEB = 1'b0; bus.WEB = 1'b1; bus.A = 12'h010;
      tick();
      bus.CEB = 1'b1;
      check_val("sleep_ready", 64'(bus.READY), 64'd0);
      for (int i = 0; i < 9; i++) begin
         if (i == 3) bus.CEB = 1'b0;
         tick();
         bus.CEB = 1'b1;
      end
      check_val("sleep_q_hold", 64'(bus.Q), 64'hCAFEF00D);
      check_val("sleep_ready_end", 64'(bus.READY), 64'd0);
      bus.SLP = 1'b0;
      tick();
      wait_ready("wake_cycles");
      for (int i = 0; i < 8; i++) rd(addrs[i]);
      drain();

      // SLP during WAKE aborts and the full count restarts
      bus.SLP = 1'b1; tick();
      bus.SLP = 1'b0; tick(); tick();
      bus.SLP = 1'b1; tick();
      check_val("wake_abort_ready", 64'(bus.READY), 64'd0);
      bus.SLP = 1'b0; tick();
      wait_ready("wake_restart_cycles");
      rd(12'h010);
      drain();

      // shutdown has priority over sleep and clears Q
      bus.SD = 1'b1; bus.SLP = 1'b1; bus.CEB = 1'b0; bus.WEB = 1'b1;
      tick();
      bus.CEB = 1'b1;
      tick();
      tick();
      check_val("sd_q_zero", 64'(bus.Q), 64'd0);
      check_val("sd_ready", 64'(bus.READY), 64'd0);
      bus.SD = 1'b0; bus.SLP = 1'b0;
      tick();
      tick();
      check_val("wake_ready_low", 64'(bus.READY), 64'd0);
      RST = 1'b1;
      tick();
      check_val("rst_mid_wake_ready", 64'(bus.READY), 64'd1);
      check_val("rst_mid_wake_qvld", 64'(bus.QVLD), 64'd0);
      RST = 1'b0;
      tick();
      wr(12'h055, 32'h0BADF00D, 32'h0, 1'b0);
      rd(12'h055);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
